lrck_monitor: RTL and testbench
===============================

LRCK_MONITOR -- requirements
Module: lrck_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flops in the lrck_in synchroniser (minimum 2).
REQ-002 Parameter PERIOD_WIDTH, default 10, width of the period counter and of the period output.
REQ-003 Parameter TOL, default 2, maximum allowed |period difference| in clk cycles for two consecutive frames to match.
REQ-004 Parameter LOCK_COUNT, default 4, number of consecutive matching periods required to declare lock.
REQ-005 clk  input  1  audio master clock; all logic is on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 lrck_in  input  1  I2S LRCK from the FX2LP side, asynchronous to clk.
REQ-008 frame_pulse  output  1  one-cycle pulse per LRCK rising edge while locked; drives a pulse_extender for the activity LED.
REQ-009 locked  output  1  high while a stable LRCK period is tracked.
REQ-010 period  output  PERIOD_WIDTH  last captured LRCK period in clk cycles; valid while locked is high.

Function
REQ-011 lrck_in SHALL pass through SYNC_STAGES flip-flops, then one history register; a rise event occurs when the synchronised value is 1 and the history value is 0.
REQ-012 A rise event SHALL be internal for exactly one cycle, SYNC_STAGES+1 clk edges after the clk edge that first samples lrck_in high.
REQ-013 The period counter cnt SHALL load 1 on a rise event, increment by 1 otherwise, and saturate at 2^PERIOD_WIDTH-1.
REQ-014 On a rise event, the captured period SHALL equal cnt before the update, so rise events N cycles apart capture N.
REQ-015 Match SHALL mean |captured - last_period| <= TOL, computed at PERIOD_WIDTH+1 bits with no wrap.
REQ-016 The FSM SHALL have states IDLE, MEASURE and LOCKED.
REQ-017 IDLE: on a rise event, go to MEASURE; clear the match count; last_period is unchanged.
REQ-018 MEASURE: on the first rise event after entry, store last_period only and do not compare.
REQ-019 MEASURE, on each later rise event: store last_period <= captured; increment the match count on a match, clear it on a mismatch.
REQ-020 MEASURE: go to LOCKED in the cycle the match count reaches LOCK_COUNT.
REQ-021 LOCKED, on a matching rise event: assert frame_pulse in that same cycle, update last_period and period.
REQ-022 LOCKED, on a mismatching rise event: go to MEASURE, clear the match count, store last_period, and do not assert frame_pulse.
REQ-023 In any state, cnt reaching saturation SHALL force IDLE and clear the match count (timeout); timeout takes priority over a simultaneous rise event.
REQ-024 locked SHALL be registered high exactly while state is LOCKED; frame_pulse SHALL never be high while locked is low.
REQ-025 period SHALL update only on rise events in LOCKED, and SHALL hold its value otherwise, including after unlock.

Reset
REQ-026 rst high SHALL, at the next clk edge, force: state IDLE; synchroniser and history registers 0; cnt 0; match count 0; last_period 0; period 0; locked 0; frame_pulse 0.
REQ-027 rst asserted mid-lock SHALL drop locked and frame_pulse on the next clk edge.
REQ-028 After rst is released, the block SHALL require a new rise event before leaving IDLE, so a high lrck_in at release causes no spurious event.

Structure
REQ-029 The FSM state encoding (IDLE, MEASURE, LOCKED) SHALL live in the shared package uac2_pkg.
REQ-030 The synchroniser SHALL be the sub-module bit_sync (parameter STAGES), reused by other CDC inputs; all other logic SHALL be in lrck_monitor.

Verification
REQ-031 lrck_in period 512 clk cycles (48 kHz at 24.576 MHz), default parameters: locked rises on the 6th rise event, period=512, then one frame_pulse per rise event at SYNC_STAGES+1 latency.
REQ-032 Locked at 512, one period of 514 then 515: no unlock (within TOL=2); one period of 520: locked drops, no frame_pulse on that edge, relock after 4 further matches.
REQ-033 lrck_in stuck low after lock: locked drops when cnt reaches 1023; period holds 512; frame_pulse stays 0.
REQ-034 rst pulsed for 1 cycle while locked and lrck_in high: all outputs 0 next cycle; no rise event until lrck_in goes low then high.
REQ-035 Rise event coinciding with the saturation cycle: state goes to IDLE, no frame_pulse.
REQ-036 Periods alternating 510/513 (difference 3 > TOL): locked never asserts.

Source files
------------

// File: rtl/uac2_pkg.sv
// Shared definitions for the UAC2 audio clocking blocks.
// Holds the LRCK monitor state encoding so other blocks and debug logic agree on it.
package uac2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } lrck_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level; STAGES cycles of latency.
// No handshake: the input is a free-running level, sampled every clk edge.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/lrck_monitor.sv
// Tracks the LRCK period in clk cycles and declares lock after LOCK_COUNT matching frames.
// Rise seen SYNC_STAGES+1 edges after lrck_in is first sampled high; no backpressure.
import uac2_pkg::*;

module lrck_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int PERIOD_WIDTH = 10,
    parameter int TOL          = 2,
    parameter int LOCK_COUNT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lrck_in,
    output logic                    frame_pulse,
    output logic                    locked,
    output logic [PERIOD_WIDTH-1:0] period
);

    localparam int MC_W   = $clog2(LOCK_COUNT + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

    logic                    w_sync;
    logic                    r_hist;
    logic                    r_armed;
    logic [FILL_W-1:0]       r_fill;
    logic                    w_rise;
    logic                    w_timeout;
    logic                    w_match;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [PERIOD_WIDTH-1:0] r_last;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH:0]   w_cap_x;
    logic [PERIOD_WIDTH:0]   w_last_x;
    logic [PERIOD_WIDTH:0]   w_diff;
    logic [MC_W-1:0]         r_mc;
    logic [MC_W-1:0]         w_mc_nxt;
    lrck_state_t             r_state;
    lrck_state_t             w_state_nxt;
    logic                    r_first;
    logic                    w_first_nxt;
    logic                    w_store_last;
    logic                    w_load_period;
    logic                    w_pulse;
    logic                    r_locked;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lrck_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (lrck_in),
        .o_sync  (w_sync)
    );

    // Edges are only trusted once the chain holds real samples and a low has been seen,
    // so an lrck_in already high when reset releases cannot fake a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist  <= 1'b0;
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_hist <= w_sync;
            if (r_fill != FILL_W'(SYNC_STAGES)) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_rise    = w_sync & ~r_hist & r_armed;
    assign w_timeout = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= PERIOD_WIDTH'(1);
        end else if (!w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One extra bit keeps the absolute difference free of wrap-around.
    assign w_cap_x  = {1'b0, r_cnt};
    assign w_last_x = {1'b0, r_last};
    assign w_diff   = (w_cap_x >= w_last_x) ? (w_cap_x - w_last_x) : (w_last_x - w_cap_x);
    assign w_match  = (w_diff <= (PERIOD_WIDTH + 1)'(TOL));

    always_comb begin
        w_state_nxt   = r_state;
        w_mc_nxt      = r_mc;
        w_first_nxt   = r_first;
        w_store_last  = 1'b0;
        w_load_period = 1'b0;
        w_pulse       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_mc_nxt    = '0;
            w_first_nxt = 1'b0;
        end else if (w_rise) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_MEASURE;
                    w_mc_nxt    = '0;
                    w_first_nxt = 1'b1;
                end
                ST_MEASURE: begin
                    w_store_last = 1'b1;
                    w_first_nxt  = 1'b0;
                    if (!r_first) begin
                        if (w_match) begin
                            w_mc_nxt = r_mc + 1'b1;
                            if (r_mc == MC_W'(LOCK_COUNT - 1)) begin
                                w_state_nxt   = ST_LOCKED;
                                w_load_period = 1'b1;
                            end
                        end else begin
                            w_mc_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_store_last = 1'b1;
                    if (w_match) begin
                        w_pulse       = 1'b1;
                        w_load_period = 1'b1;
                    end else begin
                        w_state_nxt = ST_MEASURE;
                        w_mc_nxt    = '0;
                        w_first_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_mc_nxt    = '0;
                    w_first_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mc     <= '0;
            r_first  <= 1'b0;
            r_last   <= '0;
            r_period <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc     <= w_mc_nxt;
            r_first  <= w_first_nxt;
            r_locked <= (w_state_nxt == ST_LOCKED);
            if (w_store_last) begin
                r_last <= r_cnt;
            end
            if (w_load_period) begin
                r_period <= r_cnt;
            end
        end
    end

    assign frame_pulse = w_pulse;
    assign locked      = r_locked;
    assign period      = r_period;

endmodule

// File: tb/tb_lrck_monitor.sv
// Scoreboard bench for lrck_monitor: each driven LRCK rise that should produce a
// frame_pulse pushes its expected timing and period; the output monitor pops and compares.
module tb_lrck_monitor;

    localparam int SYNC = 2;
    localparam int PW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lrck_in = 1'b0;
    logic          frame_pulse;
    logic          locked;
    logic [PW-1:0] period;

    always #5 clk = ~clk;

    lrck_monitor #(
        .SYNC_STAGES  (SYNC),
        .PERIOD_WIDTH (PW),
        .TOL          (2),
        .LOCK_COUNT   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lrck_in     (lrck_in),
        .frame_pulse (frame_pulse),
        .locked      (locked),
        .period      (period)
    );

    typedef struct {
        int t;
        int p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   prev_n   = 0;
    int   k        = 0;
    bit   pend     = 1'b0;
    int   pend_p   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard; period is checked one cycle after the pulse.
    always @(negedge clk) begin
        if (pend) begin
            check("pulse_period", period, pend_p);
            pend = 1'b0;
        end
        if (frame_pulse === 1'b1) begin
            check("pulse_locked", locked, 1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", frame_pulse, 0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_latency", cyc - mon_e.t, SYNC);
                pend   = 1'b1;
                pend_p = mon_e.p;
            end
        end
    end

    // One LRCK frame of n cycles starting with a rise; called on a negedge.
    task automatic send(input int n, input bit exp_pulse, input int exp_lock,
                        input int exp_per, input string tag);
        exp_t e;
        lrck_in = 1'b1;
        if (exp_pulse) begin
            e.t = cyc;
            e.p = prev_n;
            sb.push_back(e);
        end
        repeat (n / 2) @(negedge clk);
        check({tag, "_locked"}, locked, exp_lock);
        if (exp_per >= 0) check({tag, "_period"}, period, exp_per);
        lrck_in = 1'b0;
        repeat (n - n / 2) @(negedge clk);
        prev_n = n;
    endtask

    task automatic do_reset();
        lrck_in = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        check("rst_pulse", frame_pulse, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        @(negedge clk);
        do_reset();

        // Steady 512-cycle LRCK: lock on the 6th rise, pulses from the 7th.
        for (int i = 1; i <= 12; i++)
            send(512, i >= 7, (i >= 6) ? 1 : 0, (i >= 6) ? 512 : 0, "lock512");
        check("sb_drain_lock", sb.size(), 0);

        // Jitter inside TOL keeps lock; a jump of 5 drops it, then 4 matches relock.
        send(514, 1'b1, 1, 512, "tol_a");
        send(515, 1'b1, 1, 514, "tol_b");
        send(520, 1'b1, 1, 515, "tol_c");
        send(512, 1'b0, 0, 515, "unlock");
        send(512, 1'b0, 0, 515, "re_store");
        for (int i = 1; i <= 4; i++)
            send(512, 1'b0, (i == 4) ? 1 : 0, (i == 4) ? 512 : 515, "relock");
        send(512, 1'b1, 1, 512, "relocked");
        check("sb_drain_jitter", sb.size(), 0);

        // LRCK stops low after a rise: lock held until the counter saturates.
        lrck_in = 1'b1;
        k   = cyc;
        e.t = cyc;
        e.p = prev_n;
        sb.push_back(e);
        repeat (256) @(negedge clk);
        lrck_in = 1'b0;
        while (cyc < k + 1020) @(negedge clk);
        check("stuck_before_sat_locked", locked, 1);
        while (cyc < k + 1030) @(negedge clk);
        check("stuck_after_sat_locked", locked, 0);
        check("stuck_period_hold", period, 512);
        check("stuck_pulse", frame_pulse, 0);
        check("sb_drain_stuck", sb.size(), 0);

        // Alternating 510/513 differs by 3: never locks.
        do_reset();
        for (int i = 0; i < 12; i++)
            send((i % 2) ? 513 : 510, 1'b0, 0, 0, "alt");

        // A rise landing on the saturation cycle returns to IDLE, so relock needs 6 more rises.
        do_reset();
        for (int i = 1; i <= 7; i++)
            send(512, i == 7, (i >= 6) ? 1 : 0, (i >= 6) ? 512 : 0, "s5_lock");
        send(1023, 1'b1, 1, 512, "sat_frame");
        for (int i = 9; i <= 15; i++)
            send(512, 1'b0, (i == 15) ? 1 : 0, 512, "sat_rise");
        send(512, 1'b1, 1, 512, "sat_post");
        check("sb_drain_sat", sb.size(), 0);

        // One-cycle reset while locked with lrck_in high; no edge until a real low-high.
        lrck_in = 1'b1;
        e.t = cyc;
        e.p = prev_n;
        sb.push_back(e);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_locked", locked, 0);
        check("midrst_pulse", frame_pulse, 0);
        check("midrst_period", period, 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        lrck_in = 1'b0;
        repeat (212) @(negedge clk);
        prev_n = 512;
        for (int i = 1; i <= 6; i++)
            send(512, 1'b0, (i == 6) ? 1 : 0, (i == 6) ? 512 : 0, "post_rst");
        check("sb_drain_final", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
